// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared helpers for the programmable delay line.
//   clamp_delay : maps a requested delay onto the legal range 1..depth
//   wrap_sub    : (a - b) mod depth for a in 0..depth-1, b in 0..depth,
//                 built from a compare/select so any depth works
//   DL_ENTRY_T  : parameterised {valid, data} storage entry struct
// Optional feature macro used by the top: DELAY_LINE_OCC_EN.

`ifndef DL_ENTRY_T
`define DL_ENTRY_T(W) struct packed { logic valid; logic [(W)-1:0] data; }
`endif

package delay_line_pkg;

  function automatic int clamp_delay(input int delay, input int depth);
    if (delay < 1) return 1;
    if (delay > depth) return depth;
    return delay;
  endfunction

  function automatic int wrap_sub(input int a, input int b, input int depth);
    return (a >= b) ? (a - b) : (a + depth - b);
  endfunction

endpackage

// File: rtl/prog_delay_line_storage.sv
// dl_storage: DEPTH x (BITS+1) register array of {valid,data} entries.
// Ports:
//   clk    in   clock
//   clr    in   synchronous clear of every entry (wins over we)
//   we     in   write enable
//   wr     in   write index
//   wdata  in   {valid,data} to write
//   rd     in   read index (asynchronous read)
//   rdata  out  {valid,data} at rd

module dl_storage #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wr,
  input  logic [BITS:0] wdata,
  input  logic [AW-1:0] rd,
  output logic [BITS:0] rdata
);

  typedef `DL_ENTRY_T(BITS) entry_t;

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr] <= wdata;
    end
  end

  assign rdata = mem[rd];

endmodule

// File: rtl/prog_delay_line.sv
// prog_delay_line: ring-buffer delay line with a run-time delay of
// 1..DEPTH enabled cycles, per-entry valid bit and synchronous flush.
// Optional occupancy status (fill, primed) when DELAY_LINE_OCC_EN is defined.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (beats flush and en)
//   en       in   write d/d_valid and advance the write pointer
//   flush    in   synchronous clear of contents and pointer (beats en)
//   delay    in   requested delay; 0 acts as 1, above DEPTH acts as DEPTH
//   d        in   input data
//   d_valid  in   input qualifier
//   q        out  delayed data
//   q_valid  out  delayed qualifier
//   fill     out  saturating count of writes since reset/flush (OCC_EN)
//   primed   out  fill >= effective delay (OCC_EN)

module prog_delay_line
  import delay_line_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 64,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [DW-1:0]   delay,
  input  logic [BITS-1:0] d,
  input  logic            d_valid,
  output logic [BITS-1:0] q,
  output logic            q_valid
`ifdef DELAY_LINE_OCC_EN
  ,
  output logic [DW-1:0]   fill,
  output logic            primed
`endif
);

  typedef `DL_ENTRY_T(BITS) entry_t;

  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [DW-1:0] n_eff;
  logic          clr;
  entry_t        w_entry;
  entry_t        r_entry;

  assign clr = !rst_n || flush;

  always_comb begin
    n_eff = DW'(clamp_delay(int'(delay), DEPTH));
    // Entry written n_eff writes ago sits n_eff slots behind wr.
    rd    = AW'(wrap_sub(int'(wr), int'(n_eff), DEPTH));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr <= '0;
    end else if (en) begin
      wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + AW'(1);
    end
  end

  assign w_entry.valid = d_valid;
  assign w_entry.data  = d;

  dl_storage #(
    .DEPTH (DEPTH),
    .BITS  (BITS)
  ) u_storage (
    .clk   (clk),
    .clr   (clr),
    .we    (en),
    .wr    (wr),
    .wdata (w_entry),
    .rd    (rd),
    .rdata (r_entry)
  );

  assign q       = r_entry.data;
  assign q_valid = r_entry.valid;

`ifdef DELAY_LINE_OCC_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      fill <= '0;
    end else if (en && (fill != DW'(DEPTH))) begin
      fill <= fill + DW'(1);
    end
  end

  assign primed = (fill >= n_eff);
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed + randomized checks of prog_delay_line
// (DEPTH=8, BITS=64) against a history-queue reference model.

module tb_prog_delay_line;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int DW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            flush = 1'b0;
  logic [DW-1:0]   delay = DW'(1);
  logic [BITS-1:0] d = '0;
  logic            d_valid = 1'b0;
  logic [BITS-1:0] q;
  logic            q_valid;
`ifdef DELAY_LINE_OCC_EN
  logic [DW-1:0]   fill;
  logic            primed;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model: the most recent writes since reset/flush, oldest first.
  logic [BITS:0] hist [$];
  int            m_fill = 0;

  always #5 clk = ~clk;

  prog_delay_line #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .flush   (flush),
    .delay   (delay),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid)
`ifdef DELAY_LINE_OCC_EN
    ,
    .fill    (fill),
    .primed  (primed)
`endif
  );

  function automatic int eff_delay(input int req);
    if (req == 0) return 1;
    if (req > DEPTH) return DEPTH;
    return req;
  endfunction

  // The entry N slots back was written N writes ago; if fewer writes
  // happened since the last clear, that slot is still zero.
  function automatic logic [BITS:0] exp_entry();
    int n;
    n = eff_delay(int'(delay));
    if (hist.size() >= n) return hist[hist.size() - n];
    return '0;
  endfunction

  task automatic check(input string tag);
    logic [BITS:0] e;
    e = exp_entry();
    n_assert++;
    assert (q_valid === e[BITS]) else begin
      n_fail++;
      $error("FAIL %s q_valid: got %b expected %b", tag, q_valid, e[BITS]);
    end
    n_assert++;
    assert (q === e[BITS-1:0]) else begin
      n_fail++;
      $error("FAIL %s q: got %h expected %h", tag, q, e[BITS-1:0]);
    end
`ifdef DELAY_LINE_OCC_EN
    n_assert++;
    assert (fill === DW'(m_fill)) else begin
      n_fail++;
      $error("FAIL %s fill: got %0d expected %0d", tag, fill, m_fill);
    end
    n_assert++;
    assert (primed === (m_fill >= eff_delay(int'(delay)))) else begin
      n_fail++;
      $error("FAIL %s primed: got %b expected %b", tag, primed,
             (m_fill >= eff_delay(int'(delay))));
    end
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model, check outputs.
  task automatic step(input logic r, input logic f, input logic e,
                      input logic [BITS-1:0] dd, input logic dv, input string tag);
    rst_n   = r;
    flush   = f;
    en      = e;
    d       = dd;
    d_valid = dv;
    @(posedge clk);
    if (!r || f) begin
      hist.delete();
      m_fill = 0;
    end else if (e) begin
      hist.push_back({dv, dd});
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (m_fill < DEPTH) m_fill++;
    end
    #1;
    check(tag);
  endtask

  function automatic logic [BITS-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    // 1. reset held two cycles
    delay = DW'(3);
    step(1'b0, 1'b0, 1'b1, rnd64(), 1'b1, "reset0");
    step(1'b0, 1'b0, 1'b1, rnd64(), 1'b1, "reset1");
    n_assert++;
    assert (q === '0 && q_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_out: got q=%h v=%b expected 0/0", q, q_valid);
    end

    // 2. fixed delay 3, d = 1,2,3,...
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 1'b1, BITS'(k), 1'b1, "fixed3");
      if (k >= 3) begin
        n_assert++;
        assert (q === BITS'(k - 2) && q_valid === 1'b1) else begin
          n_fail++;
          $error("FAIL fixed3_lat: got %0d expected %0d", q, k - 2);
        end
      end
    end

    // 3. max delay across the wrap
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, "flush_a");
    delay = DW'(8);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 1'b1, BITS'(k), 1'b1, "wrap8");
      if (k >= 8) begin
        n_assert++;
        assert (q === BITS'(k - 7)) else begin
          n_fail++;
          $error("FAIL wrap8_q: got %0d expected %0d", q, k - 7);
        end
      end
    end

    // 4. clamp and stall
    delay = DW'(0);  #1; check("clamp0");
    delay = DW'(12); #1; check("clamp12");
    delay = DW'(1);  #1; check("delay1");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, rnd64(), 1'b1, "stall");
    n_assert++;
    assert (q === BITS'(20)) else begin
      n_fail++;
      $error("FAIL stall_hold: got %0d expected 20", q);
    end

    // 5. flush mid-stream with en=1 and d=0xAA
    delay = DW'(2);
    step(1'b1, 1'b0, 1'b1, rnd64(), 1'b1, "pre_flush");
    step(1'b1, 1'b1, 1'b1, BITS'(8'hAA), 1'b1, "flush_aa");
    n_assert++;
    assert (q_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL flush_qv: got %b expected 0", q_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, rnd64(), 1'b1, "refill");
      n_assert++;
      assert (!(q_valid && q === BITS'(8'hAA))) else begin
        n_fail++;
        $error("FAIL flush_leak: got %h expected not AA", q);
      end
    end

    // 6. live delay change
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, "flush_b");
    delay = DW'(2);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b1, BITS'(k), 1'b1, "live");
    n_assert++;
    assert (q === BITS'(7)) else begin
      n_fail++;
      $error("FAIL live_pre: got %0d expected 7", q);
    end
    delay = DW'(5);
    #1;
    check("live_chg");
    n_assert++;
    assert (q === BITS'(4) && q_valid === 1'b1) else begin
      n_fail++;
      $error("FAIL live_post: got %0d expected 4", q);
    end
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, "flush_c");
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b1, BITS'(k), 1'b1, "unprimed");
    delay = DW'(6); #1; check("never_written");

    // randomized traffic with occasional reset/flush and delay changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) delay = DW'($urandom_range(0, 12));
      step(($urandom_range(0, 40) != 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), rnd64(), 1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
